// File: rtl/cp0_exception_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exception_unit_if
// Brief    : Pipeline-side bundle (MEM exception info, WB MTC0, MFC0 read,
//            interrupts, flush/redirect) for the CP0 exception unit.
// Revision : 1.0
// ============================================================================
interface cp0_exception_unit_if;
  logic [8:0]  MEM_ExceptType;
  logic [31:0] MEM_PC;
  logic        MEM_IsDelaySlot;
  logic [31:0] MEM_ALUOut;
  logic        WB_CP0Wr;
  logic [4:0]  WB_Dst;
  logic [31:0] WB_OutB;
  logic [4:0]  CP0_RdAddr;
  logic [31:0] CP0_RdData;
  logic [5:0]  Ext_Int;
  logic        CP0_IntReq;
  logic        Exc_Flush;
  logic [31:0] Exc_NPC;

  modport master (
    output MEM_ExceptType, MEM_PC, MEM_IsDelaySlot, MEM_ALUOut,
    output WB_CP0Wr, WB_Dst, WB_OutB, CP0_RdAddr, Ext_Int,
    input  CP0_RdData, CP0_IntReq, Exc_Flush, Exc_NPC
  );

  modport slave (
    input  MEM_ExceptType, MEM_PC, MEM_IsDelaySlot, MEM_ALUOut,
    input  WB_CP0Wr, WB_Dst, WB_OutB, CP0_RdAddr, Ext_Int,
    output CP0_RdData, CP0_IntReq, Exc_Flush, Exc_NPC
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exception_unit
// Brief    : MIPS CP0 register file and precise-exception controller.
//            Optional timer interrupt enabled by macro CP0_TIMER_INT_EN.
// Revision : 1.0
// ============================================================================
module cp0_exception_unit (
  input  logic                 clk,
  input  logic                 rst,
  cp0_exception_unit_if.slave  bus
);
  localparam logic [4:0]  c_addr_badvaddr = 5'd8;
  localparam logic [4:0]  c_addr_count    = 5'd9;
  localparam logic [4:0]  c_addr_compare  = 5'd11;
  localparam logic [4:0]  c_addr_status   = 5'd12;
  localparam logic [4:0]  c_addr_cause    = 5'd13;
  localparam logic [4:0]  c_addr_epc      = 5'd14;
  localparam logic [31:0] c_exc_vector    = 32'hBFC0_0380;
  localparam logic [31:0] c_status_wmask  = 32'h0040_FF03;
  localparam logic [8:0]  c_non_eret_mask = 9'b1_1111_1011;
  localparam logic [8:0]  c_eret_only     = 9'b0_0000_0100;

  logic [31:0] r_count, r_epc, r_badvaddr;
  logic        r_toggle, r_bev, r_exl, r_ie, r_bd;
  logic [7:0]  r_im;
  logic [4:0]  r_exc_code;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;

  logic        w_wr_count, w_wr_status, w_wr_cause, w_wr_epc;
  logic        w_ti, w_exc, w_eret, w_badv_pc, w_badv_alu;
  logic [4:0]  w_code;
  logic [7:0]  w_ip;
  logic [31:0] w_compare_f, w_status, w_cause;
  logic [31:0] w_count_f, w_status_f, w_cause_f, w_epc_f;

  assign w_wr_count  = bus.WB_CP0Wr && (bus.WB_Dst == c_addr_count);
  assign w_wr_status = bus.WB_CP0Wr && (bus.WB_Dst == c_addr_status);
  assign w_wr_cause  = bus.WB_CP0Wr && (bus.WB_Dst == c_addr_cause);
  assign w_wr_epc    = bus.WB_CP0Wr && (bus.WB_Dst == c_addr_epc);

`ifdef CP0_TIMER_INT_EN
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_wr_compare;

  assign w_wr_compare = bus.WB_CP0Wr && (bus.WB_Dst == c_addr_compare);
  assign w_ti         = r_ti;
  assign w_compare_f  = w_wr_compare ? bus.WB_OutB : r_compare;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare <= bus.WB_OutB;
      r_ti      <= 1'b0;
    end else if (r_count == r_compare) begin
      r_ti      <= 1'b1;
    end
  end
`else
  assign w_ti        = 1'b0;
  assign w_compare_f = '0;
`endif

  // IP[7] carries the timer request on top of the top hardware line
  assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
  assign w_status = {9'd0, r_bev, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'b00};

  // Views including a same-cycle WB write, used by MFC0 and the Eret target
  assign w_count_f  = w_wr_count ? bus.WB_OutB : r_count;
  assign w_status_f = w_wr_status ? ((w_status & ~c_status_wmask) | (bus.WB_OutB & c_status_wmask))
                                  : w_status;
  assign w_cause_f  = w_wr_cause ? {w_cause[31:10], bus.WB_OutB[9:8], w_cause[7:0]} : w_cause;
  assign w_epc_f    = w_wr_epc ? bus.WB_OutB : r_epc;

  always_comb begin
    bus.CP0_RdData = '0;
    case (bus.CP0_RdAddr)
      c_addr_badvaddr: bus.CP0_RdData = r_badvaddr;
      c_addr_count:    bus.CP0_RdData = w_count_f;
      c_addr_compare:  bus.CP0_RdData = w_compare_f;
      c_addr_status:   bus.CP0_RdData = w_status_f;
      c_addr_cause:    bus.CP0_RdData = w_cause_f;
      c_addr_epc:      bus.CP0_RdData = w_epc_f;
      default:         bus.CP0_RdData = '0;
    endcase
  end

  assign w_exc  = |(bus.MEM_ExceptType & c_non_eret_mask);
  assign w_eret = (bus.MEM_ExceptType == c_eret_only);

  always_comb begin
    w_code     = 5'd0;
    w_badv_pc  = 1'b0;
    w_badv_alu = 1'b0;
    if (bus.MEM_ExceptType[8])      w_code = 5'd0;
    else if (bus.MEM_ExceptType[7]) begin w_code = 5'd4; w_badv_pc = 1'b1; end
    else if (bus.MEM_ExceptType[6]) w_code = 5'd10;
    else if (bus.MEM_ExceptType[5]) w_code = 5'd12;
    else if (bus.MEM_ExceptType[4]) w_code = 5'd8;
    else if (bus.MEM_ExceptType[3]) w_code = 5'd9;
    else if (bus.MEM_ExceptType[0]) begin w_code = 5'd4; w_badv_alu = 1'b1; end
    else if (bus.MEM_ExceptType[1]) begin w_code = 5'd5; w_badv_alu = 1'b1; end
  end

  assign bus.CP0_IntReq = r_ie & ~r_exl & (|(r_im & w_ip));
  assign bus.Exc_Flush  = ~rst & (w_exc | w_eret);
  assign bus.Exc_NPC    = rst    ? 32'd0 :
                          w_exc  ? c_exc_vector :
                          w_eret ? w_epc_f : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_toggle   <= 1'b0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_bev      <= 1'b1;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= '0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
    end else begin
      if (w_wr_count) begin
        r_count  <= bus.WB_OutB;
        r_toggle <= 1'b0;
      end else begin
        r_toggle <= ~r_toggle;
        if (r_toggle) r_count <= r_count + 32'd1;
      end
      r_ip_hw <= bus.Ext_Int;
      if (w_wr_cause) r_ip_sw <= bus.WB_OutB[9:8];
      if (w_wr_status) begin
        r_bev <= bus.WB_OutB[22];
        r_im  <= bus.WB_OutB[15:8];
        r_exl <= bus.WB_OutB[1];
        r_ie  <= bus.WB_OutB[0];
      end
      if (w_wr_epc) r_epc <= bus.WB_OutB;
      // Placed after the WB writes so exception/Eret updates take precedence
      if (w_exc) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_code;
        if (!r_exl) begin
          r_epc <= bus.MEM_IsDelaySlot ? bus.MEM_PC - 32'd4 : bus.MEM_PC;
          r_bd  <= bus.MEM_IsDelaySlot;
        end
        if (w_badv_pc)       r_badvaddr <= bus.MEM_PC;
        else if (w_badv_alu) r_badvaddr <= bus.MEM_ALUOut;
      end else if (w_eret) begin
        r_exl <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exception_unit
// Brief    : Self-checking bench for cp0_exception_unit (vector table, directed
//            corner sequences, random stimulus against a reference model).
// Revision : 1.0
// ============================================================================
module tb_cp0_exception_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_exception_unit_if bus ();
  cp0_exception_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] val, saved;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [31:0] SMASK = 32'h0040_FF03;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.MEM_ExceptType = '0; bus.MEM_PC = '0; bus.MEM_IsDelaySlot = 1'b0; bus.MEM_ALUOut = '0;
    bus.WB_CP0Wr = 1'b0; bus.WB_Dst = '0; bus.WB_OutB = '0; bus.CP0_RdAddr = '0; bus.Ext_Int = '0;
  endtask

  // All tasks start and end at posedge+1
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.WB_CP0Wr = 1'b1; bus.WB_Dst = a; bus.WB_OutB = d;
    @(posedge clk); #1;
    bus.WB_CP0Wr = 1'b0;
  endtask

  task automatic rd_get(input logic [4:0] a, output logic [31:0] v);
    bus.CP0_RdAddr = a;
    @(negedge clk); v = bus.CP0_RdData;
    @(posedge clk); #1;
  endtask

  task automatic apply_exc(input string name, input logic [8:0] t, input logic [31:0] pc,
                           input logic ds, input logic [31:0] alu);
    bus.MEM_ExceptType = t; bus.MEM_PC = pc; bus.MEM_IsDelaySlot = ds; bus.MEM_ALUOut = alu;
    @(negedge clk);
    check({name, " flush"}, 32'(bus.Exc_Flush), 32'd1);
    check({name, " npc"}, bus.Exc_NPC, VEC);
    @(posedge clk); #1;
    bus.MEM_ExceptType = '0;
  endtask

  // ---------------- reference model (architectural register words) -------------
  logic [31:0] m_badv, m_epc, m_compare, m_status, m_count_base;
  int unsigned m_cycles;
  logic        m_bd, m_ti;
  logic [5:0]  m_ext;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  int prio_bit  [8] = '{8, 7, 6, 5, 4, 3, 0, 1};
  int prio_code [8] = '{0, 4, 10, 12, 8, 9, 4, 5};

  task automatic m_reset();
    m_badv = '0; m_epc = '0; m_compare = '0; m_status = 32'h0040_0000; m_count_base = '0;
    m_cycles = 0; m_bd = 1'b0; m_ti = 1'b0; m_ext = '0; m_sw = '0; m_code = '0;
  endtask

  function automatic logic [31:0] m_count();
    return m_count_base + 32'(m_cycles >> 1);
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_ext[5] | m_ti, m_ext[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a);
    logic [31:0] r;
    r = m_read(a);
    if (bus.WB_CP0Wr && bus.WB_Dst == a) begin
      case (a)
        5'd9, 5'd14: r = bus.WB_OutB;
`ifdef CP0_TIMER_INT_EN
        5'd11:       r = bus.WB_OutB;
`endif
        5'd12:       r = (m_status & ~SMASK) | (bus.WB_OutB & SMASK);
        5'd13:       r[9:8] = bus.WB_OutB[9:8];
        default:     r = m_read(a);
      endcase
    end
    return r;
  endfunction

  task automatic m_edge();
    logic exc, eret, exl_old, wr;
    logic [31:0] cnt_now, d;
    int which;
    cnt_now = m_count();
    wr  = bus.WB_CP0Wr;
    d   = bus.WB_OutB;
    exc = |(bus.MEM_ExceptType & 9'h1FB);
    eret = (bus.MEM_ExceptType == 9'h004);
    exl_old = m_status[1];
`ifdef CP0_TIMER_INT_EN
    if (wr && bus.WB_Dst == 5'd11) begin m_compare = d; m_ti = 1'b0; end
    else if (cnt_now == m_compare) m_ti = 1'b1;
`endif
    if (wr && bus.WB_Dst == 5'd9) begin m_count_base = d; m_cycles = 0; end
    else m_cycles++;
    if (wr && bus.WB_Dst == 5'd12) m_status = (m_status & ~SMASK) | (d & SMASK);
    if (wr && bus.WB_Dst == 5'd13) m_sw = d[9:8];
    if (wr && bus.WB_Dst == 5'd14) m_epc = d;
    m_ext = bus.Ext_Int;
    if (exc) begin
      which = -1;
      for (int k = 7; k >= 0; k--) if (bus.MEM_ExceptType[prio_bit[k]]) which = k;
      m_code = 5'(prio_code[which]);
      m_status[1] = 1'b1;
      if (!exl_old) begin
        m_epc = bus.MEM_IsDelaySlot ? bus.MEM_PC - 32'd4 : bus.MEM_PC;
        m_bd  = bus.MEM_IsDelaySlot;
      end
      if (prio_bit[which] == 7) m_badv = bus.MEM_PC;
      if (prio_bit[which] <= 1) m_badv = bus.MEM_ALUOut;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [8:0]  etype;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] alu;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        chk_badv;
    logic [31:0] badv;
  } vec_t;
  vec_t vecs [9];

  typedef struct { logic [4:0] addr; logic [31:0] exp; } rvec_t;
  rvec_t rvecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [31:0] exp_cmp;
    logic [4:0] dsts [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

    vecs[0] = '{9'h020, 32'hBFC00100, 1'b0, 32'h00000000, 5'd12, 32'hBFC00100, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{9'h010, 32'h80000010, 1'b1, 32'h00000000, 5'd8,  32'h8000000C, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{9'h001, 32'h80000200, 1'b0, 32'h80000003, 5'd4,  32'h80000200, 1'b0, 1'b1, 32'h80000003};
    vecs[3] = '{9'h002, 32'h80000204, 1'b0, 32'h80000007, 5'd5,  32'h80000204, 1'b0, 1'b1, 32'h80000007};
    vecs[4] = '{9'h081, 32'h80000041, 1'b0, 32'h00001234, 5'd4,  32'h80000041, 1'b0, 1'b1, 32'h80000041};
    vecs[5] = '{9'h120, 32'h80000100, 1'b1, 32'h00000000, 5'd0,  32'h800000FC, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{9'h060, 32'h80000104, 1'b0, 32'h00000000, 5'd10, 32'h80000104, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{9'h00A, 32'h80000108, 1'b0, 32'h0000ABCD, 5'd9,  32'h80000108, 1'b0, 1'b1, 32'h80000041};
    vecs[8] = '{9'h014, 32'h80000300, 1'b0, 32'h00000000, 5'd8,  32'h80000300, 1'b0, 1'b0, 32'h0};

    rvecs[0] = '{5'd8,  32'h0};
    rvecs[1] = '{5'd9,  32'h0};
    rvecs[2] = '{5'd11, 32'h0};
    rvecs[3] = '{5'd12, 32'h00400000};
    rvecs[4] = '{5'd13, 32'h0};
    rvecs[5] = '{5'd14, 32'h0};
    rvecs[6] = '{5'd3,  32'h0};

    // ---- reset state, observed while rst is held ----
    set_idle();
    rst = 1'b1;
    bus.MEM_ExceptType = 9'h020;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      bus.CP0_RdAddr = rvecs[i].addr;
      @(negedge clk);
      check($sformatf("reset reg%0d", rvecs[i].addr), bus.CP0_RdData, rvecs[i].exp);
    end
    check("reset flush", 32'(bus.Exc_Flush), 32'd0);
    check("reset npc", bus.Exc_NPC, 32'd0);
    check("reset intreq", 32'(bus.CP0_IntReq), 32'd0);
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef CP0_TIMER_INT_EN
    wb_write(5'd11, 32'hFFFF_FFFF);
`endif
    #1;
    check("idle flush", 32'(bus.Exc_Flush), 32'd0);
    check("idle npc", bus.Exc_NPC, 32'd0);

    // ---- exception vector table ----
    for (int i = 0; i < 9; i++) begin
      wb_write(5'd12, 32'h0);
      apply_exc($sformatf("v%0d", i), vecs[i].etype, vecs[i].pc, vecs[i].ds, vecs[i].alu);
      rd_get(5'd13, val);
      check($sformatf("v%0d code", i), 32'(val[6:2]), 32'(vecs[i].code));
      check($sformatf("v%0d bd", i), 32'(val[31]), 32'(vecs[i].bd));
      rd_get(5'd14, val);
      check($sformatf("v%0d epc", i), val, vecs[i].epc);
      if (vecs[i].chk_badv) begin
        rd_get(5'd8, val);
        check($sformatf("v%0d badv", i), val, vecs[i].badv);
      end
      rd_get(5'd12, val);
      check($sformatf("v%0d exl", i), 32'(val[1]), 32'd1);
    end

    // ---- nested exception while EXL=1 keeps EPC/BD ----
    apply_exc("nested", 9'h001, 32'h90000000, 1'b1, 32'h90000001);
    rd_get(5'd14, val); check("nested epc", val, 32'h80000300);
    rd_get(5'd13, val); check("nested code", 32'(val[6:2]), 32'd4);
    check("nested bd", 32'(val[31]), 32'd0);
    rd_get(5'd8, val);  check("nested badv", val, 32'h90000001);

    // ---- exception overrides EXL of a simultaneous Status write ----
    wb_write(5'd12, 32'h0);
    bus.WB_CP0Wr = 1'b1; bus.WB_Dst = 5'd12; bus.WB_OutB = 32'h0000FF01;
    apply_exc("ovr", 9'h020, 32'h80000500, 1'b0, 32'h0);
    bus.WB_CP0Wr = 1'b0;
    rd_get(5'd12, val); check("ovr status", val, 32'h0000FF03);
    rd_get(5'd14, val); check("ovr epc", val, 32'h80000500);

    // ---- Eret with same-cycle MTC0 EPC ----
    bus.MEM_ExceptType = 9'h004;
    bus.WB_CP0Wr = 1'b1; bus.WB_Dst = 5'd14; bus.WB_OutB = 32'h80001234;
    @(negedge clk);
    check("eret flush", 32'(bus.Exc_Flush), 32'd1);
    check("eret npc", bus.Exc_NPC, 32'h80001234);
    @(posedge clk); #1;
    set_idle();
    rd_get(5'd12, val); check("eret status", val, 32'h0000FF01);
    rd_get(5'd14, val); check("eret epc", val, 32'h80001234);

    // ---- interrupt request ----
    check("int none", 32'(bus.CP0_IntReq), 32'd0);
    bus.Ext_Int = 6'b000001;
    @(negedge clk); check("int presample", 32'(bus.CP0_IntReq), 32'd0);
    @(posedge clk); #1;
    check("int ext", 32'(bus.CP0_IntReq), 32'd1);
    rd_get(5'd13, val); check("int cause ip", 32'(val[15:8]), 32'h04);
    bus.Ext_Int = 6'b0;
    @(posedge clk); #1;
    check("int ext clr", 32'(bus.CP0_IntReq), 32'd0);
    wb_write(5'd13, 32'h0000_0100);
    check("int sw", 32'(bus.CP0_IntReq), 32'd1);
    wb_write(5'd12, 32'h0000FE01);
    check("int masked", 32'(bus.CP0_IntReq), 32'd0);
    wb_write(5'd12, 32'h0000FF03);
    check("int exl", 32'(bus.CP0_IntReq), 32'd0);
    wb_write(5'd13, 32'h0);
    wb_write(5'd12, 32'h0);

    // ---- read forwarding ----
    saved = 32'h90000001;
    bus.CP0_RdAddr = 5'd9;
    wb_write(5'd9, 32'h12345678);
    bus.CP0_RdAddr = 5'd9; bus.WB_CP0Wr = 1'b1; bus.WB_Dst = 5'd9; bus.WB_OutB = 32'hCAFE0000;
    @(negedge clk); check("fwd count", bus.CP0_RdData, 32'hCAFE0000);
    bus.WB_Dst = 5'd8; bus.WB_OutB = 32'hDEADBEEF; bus.CP0_RdAddr = 5'd8;
    #1; check("fwd badv ro", bus.CP0_RdData, saved);
    bus.WB_Dst = 5'd7; bus.CP0_RdAddr = 5'd7;
    #1; check("fwd unmapped", bus.CP0_RdData, 32'd0);
    bus.WB_Dst = 5'd11; bus.WB_OutB = 32'h55; bus.CP0_RdAddr = 5'd11;
`ifdef CP0_TIMER_INT_EN
    exp_cmp = 32'h55;
`else
    exp_cmp = 32'h0;
`endif
    #1; check("fwd compare", bus.CP0_RdData, exp_cmp);
    @(posedge clk); #1;
    bus.WB_CP0Wr = 1'b0;
    rd_get(5'd8, val); check("badv kept", val, saved);
    rd_get(5'd11, val); check("compare rd", val, exp_cmp);

    // ---- Count: every second clock, wrap to 0 ----
    wb_write(5'd9, 32'hFFFF_FFFE);
    rd_get(5'd9, val); check("cnt0", val, 32'hFFFF_FFFE);
    rd_get(5'd9, val); check("cnt1", val, 32'hFFFF_FFFE);
    rd_get(5'd9, val); check("cnt2", val, 32'hFFFF_FFFF);
    rd_get(5'd9, val); check("cnt3", val, 32'hFFFF_FFFF);
    rd_get(5'd9, val); check("cnt wrap", val, 32'h0);

    // ---- reset asserted mid-cycle with an exception in flight ----
    wb_write(5'd9, 32'h55);
    bus.MEM_ExceptType = 9'h020; bus.MEM_PC = 32'h80000700; bus.CP0_RdAddr = 5'd9;
    #2; rst = 1'b1; #1;
    check("mrst count", bus.CP0_RdData, 32'h0);
    bus.CP0_RdAddr = 5'd12; #1;
    check("mrst status", bus.CP0_RdData, 32'h00400000);
    check("mrst flush", 32'(bus.Exc_Flush), 32'd0);
    check("mrst npc", bus.Exc_NPC, 32'd0);
    set_idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rd_get(5'd14, val); check("mrst epc", val, 32'h0);
    rd_get(5'd12, val); check("mrst exl", val, 32'h00400000);

`ifdef CP0_TIMER_INT_EN
    // ---- timer interrupt ----
    wb_write(5'd12, 32'h0000_8001);
    wb_write(5'd11, 32'd10);
    wb_write(5'd9, 32'd0);
    seen = -1;
    for (int k = 1; k <= 40 && seen < 0; k++) begin
      @(posedge clk); #1;
      if (bus.CP0_IntReq) seen = k;
    end
    check("timer latency ok", 32'(seen >= 20 && seen <= 22), 32'd1);
    wb_write(5'd11, 32'd1000);
    check("timer cleared", 32'(bus.CP0_IntReq), 32'd0);
`endif

    // ---- random stimulus vs reference model ----
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        5:       bus.MEM_ExceptType = 9'h004;
        6, 7:    bus.MEM_ExceptType = 9'($urandom);
        default: bus.MEM_ExceptType = '0;
      endcase
      bus.MEM_PC = $urandom; bus.MEM_ALUOut = $urandom; bus.MEM_IsDelaySlot = 1'($urandom);
      bus.Ext_Int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      bus.WB_CP0Wr = ($urandom_range(0, 2) == 0);
      bus.WB_Dst = ($urandom_range(0, 7) == 0) ? 5'($urandom) : dsts[$urandom_range(0, 6)];
      bus.WB_OutB = $urandom;
      bus.CP0_RdAddr = ($urandom_range(0, 1) == 0) ? bus.WB_Dst : dsts[$urandom_range(0, 6)];
      @(negedge clk);
      check($sformatf("rnd%0d rd%0d", n, bus.CP0_RdAddr), bus.CP0_RdData, m_fwd(bus.CP0_RdAddr));
      check($sformatf("rnd%0d intreq", n), 32'(bus.CP0_IntReq),
            32'(m_status[0] & ~m_status[1] & (|(m_status[15:8] & m_ip()))));
      check($sformatf("rnd%0d flush", n), 32'(bus.Exc_Flush), 32'(bus.MEM_ExceptType != 9'h0));
      check($sformatf("rnd%0d npc", n), bus.Exc_NPC,
            (|(bus.MEM_ExceptType & 9'h1FB)) ? VEC :
            (bus.MEM_ExceptType == 9'h004) ? m_fwd(5'd14) : 32'd0);
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp0_exception_unit.md
CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

Interface
REQ-001 SHALL provide: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL provide: MEM_ExceptType  in  9  ExceptinPipeType packed, bit8 Interrupt .. bit0 RdWrongAddressinMEM.
REQ-004 SHALL provide: MEM_PC  in  32  PC of the instruction in MEM.
REQ-005 SHALL provide: MEM_IsDelaySlot  in  1  MEM instruction sits in a branch delay slot.
REQ-006 SHALL provide: MEM_ALUOut  in  32  data address of the MEM load/store.
REQ-007 SHALL provide: WB_CP0Wr  in  1, WB_Dst  in  5, WB_OutB  in  32  MTC0 write enable, address and data from WB.
REQ-008 SHALL provide: CP0_RdAddr  in  5, CP0_RdData  out  32  combinational MFC0 read port.
REQ-009 SHALL provide: Ext_Int  in  6  hardware interrupt lines, mapped to Cause.IP[7:2].
REQ-010 SHALL provide: CP0_IntReq  out  1  interrupt pending, sampled by ID into the Interrupt bit.
REQ-011 SHALL provide: Exc_Flush  out  1 and Exc_NPC  out  32  pipeline flush and redirect target.

Function
REQ-012 SHALL implement BadVAddr(8, read-only), Count(9), Compare(11), Status(12: IM[15:8], EXL[1], IE[0]), Cause(13: BD[31], TI[30], IP[15:8], ExcCode[6:2]) and EPC(14); other addresses read 0 and ignore writes.
REQ-013 SHALL write a register on the edge after WB_CP0Wr=1; only IP[1:0] of Cause is writable; MFC0 read SHALL forward a same-cycle WB write to the same address.
REQ-014 SHALL increment Count every second clk via an internal toggle bit, wrapping 0xFFFFFFFF->0; a Count write in the same cycle wins and clears the toggle.
REQ-015 SHALL sample Ext_Int into Cause.IP[7:2] every cycle.
REQ-016 SHALL assert CP0_IntReq = IE & ~EXL & |(IM & IP), combinationally.
REQ-017 SHALL, when any non-Eret bit of MEM_ExceptType is set, assert Exc_Flush and drive Exc_NPC=0xBFC00380 in the same cycle.
REQ-018 SHALL select ExcCode by priority Interrupt(0) > WrongAddressinIF(4) > ReservedInstruction(10) > Overflow(12) > Syscall(8) > Break(9) > RdWrongAddressinMEM(4) > WrWrongAddressinMEM(5).
REQ-019 SHALL on the accepting edge set EXL=1 and ExcCode; if EXL was 0, set EPC = MEM_IsDelaySlot ? MEM_PC-4 : MEM_PC and BD = MEM_IsDelaySlot; if EXL was 1, leave EPC and BD unchanged.
REQ-020 SHALL load BadVAddr with MEM_PC for WrongAddressinIF and with MEM_ALUOut for the MEM address errors.
REQ-021 SHALL, for Eret alone, assert Exc_Flush, drive Exc_NPC=EPC (forwarding a same-cycle WB write to EPC), and clear EXL on the edge.
REQ-022 SHALL let exception updates to EXL/EPC/BD/ExcCode/BadVAddr override a simultaneous WB_CP0Wr to the same fields; other fields still take the write.
REQ-023 SHALL hold Exc_Flush=0 and Exc_NPC=0 when MEM_ExceptType is all zero.

Reset
REQ-024 SHALL on rst clear Count, Compare, Cause, EPC, BadVAddr and the toggle bit, and set Status=0x0040_0000 (BEV=1, EXL=0, IE=0); CP0_IntReq=0, Exc_Flush=0.
REQ-025 SHALL abandon any in-progress exception when rst asserts mid-cycle; no register retains a partial update.

Configuration
REQ-026 SHALL with CP0_TIMER_INT_EN defined set Cause.TI when Count==Compare, OR TI into IP[7], and clear TI on any Compare write.
REQ-027 SHALL without CP0_TIMER_INT_EN read Compare and TI as 0, ignore Compare writes, and drive IP[7] from Ext_Int[5] only.

Verification
REQ-028 SHALL cover: MEM_ExceptType=Overflow, MEM_PC=0xBFC00100, delay slot=0 -> Exc_NPC=0xBFC00380, next cycle EPC=0xBFC00100, ExcCode=12, EXL=1.
REQ-029 SHALL cover: Syscall in delay slot at MEM_PC=0x80000010 -> EPC=0x8000000C, BD=1, ExcCode=8.
REQ-030 SHALL cover: Eret with simultaneous WB MTC0 EPC=0x80001234 -> Exc_NPC=0x80001234, EXL cleared next cycle.
REQ-031 SHALL cover: RdWrongAddressinMEM with MEM_ALUOut=0x80000003 -> BadVAddr=0x80000003, ExcCode=4; a second exception while EXL=1 leaves EPC unchanged.
REQ-032 SHALL cover (CP0_TIMER_INT_EN): Compare=10, Status IM7=1 IE=1 -> CP0_IntReq=1 after 20 cycles; Compare write clears it.
REQ-033 SHALL cover: rst asserted mid-count -> Count=0, Status=0x00400000 immediately, Exc_Flush=0.
